// File: rtl/shift_sequencer.sv
// Multi-step shift controller in front of a combinational single-step 4-bit shifter.
// Each SHIFT cycle feeds the operand register to the shifter and reloads it with the result.
module shift_sequencer #(
    parameter int WIDTH = 4,
    parameter int AMT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_dir,
    input  logic [AMT_W-1:0] in_amt,
    output logic [WIDTH-1:0] sh_a,
    output logic             sh_c,
    output logic             sh_e,
    input  logic [WIDTH-1:0] sh_s,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero,
    output logic             out_carry
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic             dir_q, dir_d;
    logic [AMT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             zero_q, zero_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            opnd_q  <= '0;
            dir_q   <= 1'b0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            opnd_q  <= opnd_d;
            dir_q   <= dir_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            zero_q  <= zero_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        opnd_d    = opnd_q;
        dir_d     = dir_q;
        cnt_d     = cnt_q;
        carry_d   = carry_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        sh_e      = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    opnd_d  = in_data;
                    dir_d   = in_dir;
                    cnt_d   = in_amt;
                    carry_d = 1'b0;
                    state_d = (in_amt != '0) ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                sh_e    = 1'b1;
                opnd_d  = sh_s;
                // the bit falling off the end this step becomes the carry
                carry_d = dir_q ? opnd_q[0] : opnd_q[WIDTH-1];
                cnt_d   = cnt_q - AMT_W'(1);
                if (cnt_q == AMT_W'(1)) state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // zero flag tracks the operand register so it is stable with out_data
        zero_d = (opnd_d == '0);
    end

    assign sh_a      = opnd_q;
    assign sh_c      = dir_q;
    assign out_data  = opnd_q;
    assign out_zero  = zero_q;
    assign out_carry = carry_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: directed cases, then random requests checked
// against an arithmetic reference of multi-bit shifts.
module tb_shift_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, in_ready, in_dir;
    logic [3:0] in_data;
    logic [2:0] in_amt;
    logic [3:0] sh_a, sh_s;
    logic       sh_c, sh_e;
    logic       out_valid, out_ready, out_zero, out_carry;
    logic [3:0] out_data;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    // single-step shifter the block drives
    assign sh_s = !sh_e ? 4'd0 : (sh_c ? (sh_a >> 1) : (sh_a << 1));

    shift_sequencer #(.WIDTH(4), .AMT_W(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_dir(in_dir), .in_amt(in_amt),
        .sh_a(sh_a), .sh_c(sh_c), .sh_e(sh_e), .sh_s(sh_s),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_zero(out_zero), .out_carry(out_carry)
    );

    function automatic logic [3:0] ref_res(input logic [3:0] d, input logic dir, input int amt);
        int v;
        v = int'(d);
        v = dir ? (v >> amt) : (v << amt);
        return v[3:0];
    endfunction

    function automatic logic ref_carry(input logic [3:0] d, input logic dir, input int amt);
        int v;
        if (amt == 0) return 1'b0;
        v = int'(d);
        v = dir ? (v >> (amt - 1)) : (v << (amt - 1));
        return dir ? v[0] : v[3];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one request, follow it to DONE, hold it for 'hold' cycles, then pop it.
    task automatic run_req(input logic [3:0] d, input logic dir, input int amt, input int hold);
        logic [3:0] exp_d;
        logic       exp_c;
        int edges, se_cnt;
        exp_d = ref_res(d, dir, amt);
        exp_c = ref_carry(d, dir, amt);
        chk("in_ready_idle", in_ready, 1'b1);
        in_valid = 1'b1; in_data = d; in_dir = dir; in_amt = 3'(amt);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data = 4'($urandom); in_dir = 1'($urandom); in_amt = 3'($urandom);
        edges = 1; se_cnt = 0;
        while (out_valid !== 1'b1 && edges < 20) begin
            if (sh_e === 1'b1) begin
                chk("sh_a_step", sh_a, ref_res(d, dir, se_cnt));
                chk("sh_c_step", sh_c, dir);
                se_cnt++;
            end
            @(posedge clk); #1;
            edges++;
        end
        chk("latency", edges, amt + 1);
        chk("sh_e_cycles", se_cnt, amt);
        for (int h = 0; h <= hold; h++) begin
            chk("out_valid", out_valid, 1'b1);
            chk("out_data", out_data, exp_d);
            chk("out_carry", out_carry, exp_c);
            chk("out_zero", out_zero, exp_d == 4'd0);
            chk("in_ready_done", in_ready, 1'b0);
            chk("sh_e_done", sh_e, 1'b0);
            if (h == hold) out_ready = 1'b1;
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
        chk("out_valid_pop", out_valid, 1'b0);
        chk("in_ready_after_pop", in_ready, 1'b1);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_dir = 1'b0; in_amt = '0;
        out_ready = 1'b0;
        #12;
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_sh_e", sh_e, 1'b0);
        chk("rst_out_data", out_data, 4'd0);
        chk("rst_out_carry", out_carry, 1'b0);
        chk("rst_out_zero", out_zero, 1'b0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_req(4'b1011, 1'b0, 1, 0);
        run_req(4'b1011, 1'b1, 2, 0);
        run_req(4'b1001, 1'b0, 0, 0);
        run_req(4'b1111, 1'b0, 6, 0);
        run_req(4'b0110, 1'b1, 3, 5);
        run_req(4'b1000, 1'b1, 4, 1);

        // reset mid-SHIFT aborts without a clock edge
        in_valid = 1'b1; in_data = 4'b1101; in_dir = 1'b0; in_amt = 3'd6;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("pre_abort_sh_e", sh_e, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_in_ready", in_ready, 1'b1);
        chk("abort_out_valid", out_valid, 1'b0);
        chk("abort_out_data", out_data, 4'd0);
        chk("abort_sh_e", sh_e, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_abort_out_valid", out_valid, 1'b0);

        for (int i = 0; i < 40; i++)
            run_req(4'($urandom), 1'($urandom), int'($urandom_range(0, 7)),
                    int'($urandom_range(0, 3)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
